multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RISC-V core: walks each instruction through fetch, decode
// and execute phases and drives every datapath select/enable from the current state.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [2:0] result_src,
  output logic [2:0] imm_src,
  output logic       branch,
  output logic       instr_retired,
  output logic       illegal_instr
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpL     = 7'b0000011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StJalr     = 4'd12,
    StLui      = 4'd13,
    StAuipc    = 4'd14,
    StTrap     = 4'd15
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    result_src    = 3'b000;
    imm_src       = 3'b000;
    branch        = 1'b0;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 4'b0010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute old_pc + imm so branch/JAL targets sit in alu_out.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 4'b0010;
        case (opcode)
          OpS:     imm_src = 3'b001;
          OpB:     imm_src = 3'b010;
          OpLui:   imm_src = 3'b011;
          OpJal:   imm_src = 3'b100;
          OpAuipc: imm_src = 3'b101;
          default: imm_src = 3'b000;
        endcase
        case (opcode)
          OpR:      state_d = StExecR;
          OpI:      state_d = StExecI;
          OpL, OpS: state_d = StMemAdr;
          OpB:      state_d = StBranch;
          OpJal:    state_d = StJal;
          OpJalr:   state_d = StJalr;
          OpLui:    state_d = StLui;
          OpAuipc:  state_d = StAuipc;
          default:  state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 4'b0010;
        imm_src   = (opcode == OpS) ? 3'b001 : 3'b000;
        state_d   = (opcode == OpS) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write     = 1'b1;
        result_src    = 3'b001;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        mem_req       = 1'b1;
        mem_write     = 1'b1;
        adr_src       = 1'b1;
        instr_retired = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 4'b0001;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        branch        = 1'b1;
        alu_src_a     = 2'b10;
        alu_op        = 4'b0100;
        pc_src        = 1'b1;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        reg_write     = 1'b1;
        result_src    = 3'b010;
        imm_src       = 3'b100;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StJalr: begin
        alu_src_a     = 2'b10;
        alu_src_b     = 2'b01;
        alu_op        = 4'b1000;
        pc_write      = 1'b1;
        reg_write     = 1'b1;
        result_src    = 3'b010;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StLui: begin
        reg_write     = 1'b1;
        result_src    = 3'b011;
        imm_src       = 3'b011;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StAuipc: begin
        reg_write     = 1'b1;
        result_src    = 3'b100;
        imm_src       = 3'b101;
        instr_retired = 1'b1;
        state_d       = StFetch;
      end
      StTrap: illegal_instr = 1'b1;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table of instructions with a retirement
// scoreboard, plus hand-written reset, trap and abandoned-handshake sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready, branch_taken;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write;
  logic [1:0] alu_src_a, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] result_src, imm_src;
  logic       branch, instr_retired, illegal_instr;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] a, b;
    logic [3:0] alu_op;
    logic [2:0] res, imm;
    logic       branch, retired, illegal;
  } outs_t;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        bt;
    logic [31:0] mask;    // mem_ready per cycle, bit i = cycle i from FETCH
    int          cycles;
    int          chk_idx;
    outs_t       chk;
    outs_t       fin;
  } vec_t;

  typedef struct {
    int    idx;
    int    cycles;
    outs_t fin;
  } sb_t;

  outs_t act;
  vec_t  vecs[11];
  sb_t   q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .branch(branch),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  always_comb begin
    act = '{mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write, alu_src_a,
            alu_src_b, alu_op, result_src, imm_src, branch, instr_retired, illegal_instr};
  end

  // Expected output vectors per state, written straight from the state table.
  function automatic outs_t e_fetch(logic rdy);
    outs_t o = '0; o.mem_req = 1; o.b = 2'b10; o.alu_op = 4'b0010;
    o.ir_write = rdy; o.pc_write = rdy; return o;
  endfunction
  function automatic outs_t e_decode(logic [2:0] imm);
    outs_t o = '0; o.a = 2'b01; o.b = 2'b01; o.alu_op = 4'b0010; o.imm = imm; return o;
  endfunction
  function automatic outs_t e_memadr(logic [2:0] imm);
    outs_t o = '0; o.a = 2'b10; o.b = 2'b01; o.alu_op = 4'b0010; o.imm = imm; return o;
  endfunction
  function automatic outs_t e_memread();
    outs_t o = '0; o.mem_req = 1; o.adr_src = 1; return o;
  endfunction
  function automatic outs_t e_wb(logic [2:0] res, logic [2:0] imm);
    outs_t o = '0; o.reg_write = 1; o.res = res; o.imm = imm; o.retired = 1; return o;
  endfunction
  function automatic outs_t e_memwrite();
    outs_t o = '0; o.mem_req = 1; o.mem_write = 1; o.adr_src = 1; o.retired = 1; return o;
  endfunction
  function automatic outs_t e_exec(logic [1:0] b, logic [3:0] op);
    outs_t o = '0; o.a = 2'b10; o.b = b; o.alu_op = op; return o;
  endfunction
  function automatic outs_t e_branch(logic bt);
    outs_t o = '0; o.branch = 1; o.a = 2'b10; o.alu_op = 4'b0100; o.pc_src = 1;
    o.pc_write = bt; o.retired = 1; return o;
  endfunction
  function automatic outs_t e_jal();
    outs_t o = '0; o.pc_write = 1; o.pc_src = 1; o.reg_write = 1; o.res = 3'b010;
    o.imm = 3'b100; o.retired = 1; return o;
  endfunction
  function automatic outs_t e_jalr();
    outs_t o = '0; o.a = 2'b10; o.b = 2'b01; o.alu_op = 4'b1000; o.pc_write = 1;
    o.reg_write = 1; o.res = 3'b010; o.retired = 1; return o;
  endfunction
  function automatic outs_t e_trap();
    outs_t o = '0; o.illegal = 1; return o;
  endfunction

  function automatic vec_t mk(string n, logic [6:0] op, logic bt, logic [31:0] mask, int cyc,
                              int ci, outs_t c, outs_t f);
    vec_t v;
    v.name = n; v.op = op; v.bt = bt; v.mask = mask; v.cycles = cyc;
    v.chk_idx = ci; v.chk = c; v.fin = f;
    return v;
  endfunction

  task automatic check(string nm, outs_t got, outs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  task automatic check_int(string nm, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // Entered just after the edge that starts FETCH; returns just after the next FETCH edge.
  task automatic run_instr(int k);
    vec_t v;
    sb_t  e;
    bit   done;
    v = vecs[k];
    done = 0;
    e.idx = k; e.cycles = v.cycles; e.fin = v.fin;
    q.push_back(e);
    opcode = v.op;
    branch_taken = v.bt;
    for (int i = 0; i < 20 && !done; i++) begin
      mem_ready = v.mask[i];
      @(negedge clk);
      if (i == v.chk_idx) check({v.name, "_mid"}, act, v.chk);
      if (act.retired) begin
        done = 1;
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL %s_sb: got retire required none pending", v.name);
        end else begin
          e = q.pop_front();
          check_int({vecs[e.idx].name, "_cycles"}, i + 1, e.cycles);
          check({vecs[e.idx].name, "_final"}, act, e.fin);
        end
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no retire required retire in %0d cycles", v.name, v.cycles);
      if (q.size() != 0) void'(q.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = mk("jalr", 7'b1100111, 0, '1, 3, 0, e_fetch(1), e_jalr());
    vecs[1]  = mk("sw_fwait", 7'b0100011, 0, 32'hFFFF_FFFE, 5, 0, e_fetch(0), e_memwrite());
    vecs[2]  = mk("add", 7'b0110011, 0, '1, 4, 2, e_exec(2'b00, 4'b0000), e_wb(3'b000, 3'b000));
    vecs[3]  = mk("addi", 7'b0010011, 0, '1, 4, 2, e_exec(2'b01, 4'b0001),
                  e_wb(3'b000, 3'b000));
    vecs[4]  = mk("lw_wait", 7'b0000011, 0, 32'hFFFF_FFE7, 7, 4, e_memread(),
                  e_wb(3'b001, 3'b000));
    vecs[5]  = mk("beq_nt", 7'b1100011, 0, '1, 3, 1, e_decode(3'b010), e_branch(0));
    vecs[6]  = mk("beq_t", 7'b1100011, 1, '1, 3, 1, e_decode(3'b010), e_branch(1));
    vecs[7]  = mk("jal", 7'b1101111, 0, '1, 3, 1, e_decode(3'b100), e_jal());
    vecs[8]  = mk("lui", 7'b0110111, 0, '1, 3, 1, e_decode(3'b011), e_wb(3'b011, 3'b011));
    vecs[9]  = mk("auipc", 7'b0010111, 0, '1, 3, 1, e_decode(3'b101), e_wb(3'b100, 3'b101));
    vecs[10] = mk("sw", 7'b0100011, 0, '1, 4, 2, e_memadr(3'b001), e_memwrite());

    rst_n = 0; mem_ready = 1; branch_taken = 0; opcode = 7'b1100111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", act, '0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("idle_after_reset", act, '0);
    @(posedge clk); #1;

    for (int k = 0; k < 11; k++) run_instr(k);

    // Illegal opcode: FETCH, DECODE, then TRAP held until reset.
    opcode = 7'b0000000;
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) check("trap_enter", act, e_trap());
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("trap_hold", act, e_trap());
    end
    rst_n = 0;
    #1 check("trap_reset", act, '0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("idle_after_trap", act, '0);

    // Reset while FETCH waits on memory drops the request without a clock edge.
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    check("fetch_wait", act, e_fetch(0));
    #2 rst_n = 0;
    #1 check("abandon_req", act, '0);
    @(posedge clk); #1;
    rst_n = 1;

    check_int("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
